mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder on the CPU memory bus, serving the upper half of the 9-bit address space (mem_addr[8]=1) that the RAM ignores. It decodes the same mem_cmd/mem_addr/write_data transactions as the RAM and answers reads with the same one-clock registered latency. It owns the LED register, the synchronized switch inputs, a prescaled 16-bit timer with compare flag, and a 16-bit hex display register. It sits beside RAM in the top level and shares read_data.

## Interface
- PRESCALE, 1000: clock cycles per timer tick; legal range is 1..65535.
- clk  in  1  system clock, the same clock as the CPU and RAM.
- reset  in  1  reset, synchronous and active-high.
- mem_cmd  in  2  bus command: 00 MNONE, 01 MREAD, 10 MWRITE, 11 treated as MNONE.
- mem_addr  in  9  bus address. The block is selected when mem_addr[8]=1.
- write_data  in  16  CPU store data.
- read_data  out  16  response data. Driven only when selected and mem_cmd=MREAD; high-Z otherwise.
- sw  in  10  raw slide switches, asynchronous to clk.
- ledr  out  10  LED register.
- hex0..hex3  out  7 each  active-low seven-segment digits of the hex register. hex0 shows the least-significant nibble.

## Operation
- Select: sel = mem_addr[8]. rd = sel & (mem_cmd==MREAD). wr = sel & (mem_cmd==MWRITE).
- Address map (full 9-bit compare):
  - 0x100 LED: read/write. Holds bits [9:0]. Reads return {6'b0, led}.
  - 0x140 SW: read-only. Returns {6'b0, sw_sync}.
  - 0x180 TCOUNT: read. Any write clears it to 0 and also clears the prescaler.
  - 0x181 TCMP: read/write, 16 bits.
  - 0x182 STATUS: bit0 = match flag. Reads return {15'b0, flag}. A read clears the flag. Writes are ignored.
  - 0x1C0 HEX: read/write, 16 bits.
  - Any other selected address reads 0 and ignores writes.
- Switch path: two-flop synchronizer. sw_sync is the second stage.
- Timer:
  - The prescaler counts 0..PRESCALE-1 and then wraps.
  - On the wrap cycle, tick=1 and TCOUNT increments, wrapping from 0xFFFF to 0x0000.
  - When TCOUNT's next value equals TCMP on a tick, the flag sets.
- Display: each HEX nibble is decoded for digits 0-F. A segment is on when its bit is 0.

## Timing
- Writes take effect at the posedge where wr=1. The new value is visible on ledr/hex on the next cycle.
- Read latency is 1 clock, matching RAM:
  - At a posedge with rd=1, rdata_q captures the addressed value.
  - read_data = rdata_q whenever rd=1, else Z.
  - The CPU holds MREAD for 2 cycles and samples on the second.
- Read-to-clear of STATUS happens at the capture edge, so rdata_q holds the pre-clear flag.
- If a read of STATUS and a new match occur at the same edge, the flag stays 1 (set wins). rdata_q returns the old value.
- A TCOUNT write coinciding with a tick: the write wins, giving count 0 and prescaler 0. No match evaluation occurs that cycle.
- A TCMP write coinciding with a tick: the match compares against the old TCMP.
- Reset values:
  - led = 0, so ledr = 0.
  - hex = 0x0000, so every digit shows "0" (7'b1000000).
  - TCOUNT = 0, prescaler = 0, TCMP = 0xFFFF, flag = 0.
  - rdata_q = 0, synchronizer flops = 0.
- Reset mid-transaction: reset dominates all writes, ticks and clears in that cycle. read_data still follows rd combinationally.
- mem_cmd=11 and all unselected cycles cause no state change.

## Structure
- Shared package mem_bus_pkg holds:
  - MNONE/MREAD/MWRITE command codes.
  - Address constants: IO_LED, IO_SW, IO_TCOUNT, IO_TCMP, IO_STATUS, IO_HEX.
  - Display constants SEG_ZERO/SEG_BLANK.
- The RAM and top level import the same command codes.
- Sub-module: seg7_decode (4-bit nibble in, 7-bit active-low segments out), instantiated 4 times. It is purely combinational.
- The responder body holds the register file, synchronizer, prescaler/timer, read mux and tri-state.

## Test plan
- Reset, then write 0x100 = 0x02A5 (MWRITE 1 cycle) -> ledr=10'h2A5 next cycle. A 2-cycle MREAD of 0x100 returns 0x02A5 on cycle 2.
- Drive sw=10'h3C1 with a 2-cycle MREAD of 0x140 issued 3 cycles later -> read_data=0x03C1. With mem_addr=0x040 and MREAD, read_data is Z.
- PRESCALE=4, TCMP=3 -> TCOUNT reaches 3 after 12 cycles and the flag sets. Reading STATUS returns 1. The next read returns 0.
- STATUS read on the exact edge the flag sets -> the read returns 0 and the flag remains 1. A TCOUNT write on a tick edge -> TCOUNT=0.
- Write 0x1C0 = 0x1F80 -> hex3=7'b1111001, hex2=7'b0001110, hex1=7'b0000000, hex0=7'b1000000.
- Assert reset while a TCOUNT=0x0005 count is running and the flag=1 -> all registers return to their reset values, including TCMP=0xFFFF and ledr=0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_pkg
// Brief  : Shared CPU memory-bus command codes, MMIO address map and
//          seven-segment display constants.
// Rev    : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    // Bus command codes (2'b11 is treated as no-operation)
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // MMIO address map (upper half of the 9-bit space)
    localparam logic [8:0] IO_LED    = 9'h100;
    localparam logic [8:0] IO_SW     = 9'h140;
    localparam logic [8:0] IO_TCOUNT = 9'h180;
    localparam logic [8:0] IO_TCMP   = 9'h181;
    localparam logic [8:0] IO_STATUS = 9'h182;
    localparam logic [8:0] IO_HEX    = 9'h1C0;

    // Active-low seven-segment patterns, bit 0 = segment a
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // The responder claims every address with the top bit set
    function automatic logic io_sel(input logic [8:0] addr);
        return addr[8];
    endfunction

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mmio_responder_if.sv
`default_nettype none
// ============================================================================
// Module : mmio_responder_if
// Brief  : CPU memory-bus bundle shared by RAM and the MMIO responder.
//          read_data is a shared tri-state return path.
// Rev    : 1.0  initial release
// ============================================================================
interface mmio_responder_if;

    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    wire  [15:0] read_data;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data
    );

endinterface : mmio_responder_if
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module : seg7_decode
// Brief  : Hex nibble to active-low seven-segment pattern (gfedcba).
// Rev    : 1.0  initial release
// ============================================================================
module seg7_decode
    import mem_bus_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup of the glyph for digits 0-F
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module : mmio_responder
// Brief  : MMIO responder for the upper half of the CPU address space:
//          LED register, synchronized switches, prescaled 16-bit timer with
//          compare flag, and a 16-bit hex display register. Reads have one
//          clock of registered latency, matching the RAM.
// Rev    : 1.0  initial release
// ============================================================================
module mmio_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic              clk,
    input  logic              reset,
    mmio_responder_if.slave   bus,
    input  logic [9:0]        sw,
    output logic [9:0]        ledr,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3
);

    localparam logic [15:0] C_PRE_MAX = 16'(PRESCALE - 1);

    logic [9:0]  r_led;
    logic [15:0] r_hex;
    logic [15:0] r_tcmp;
    logic [15:0] r_count;
    logic [15:0] r_pre;
    logic        r_flag;
    logic [15:0] r_rdata;
    logic [9:0]  r_sw_meta;
    logic [9:0]  r_sw_sync;

    logic        w_rd;
    logic        w_wr;
    logic        w_tick;
    logic        w_tcount_wr;
    logic        w_status_rd;
    logic [15:0] w_count_nxt;
    logic        w_match;
    logic [15:0] w_rd_mux;
    logic [6:0]  w_seg [4];

    // Bus decode and timer event terms
    assign w_rd        = io_sel(bus.mem_addr) && (bus.mem_cmd == MREAD);
    assign w_wr        = io_sel(bus.mem_addr) && (bus.mem_cmd == MWRITE);
    assign w_tcount_wr = w_wr && (bus.mem_addr == IO_TCOUNT);
    assign w_status_rd = w_rd && (bus.mem_addr == IO_STATUS);
    assign w_tick      = (r_pre == C_PRE_MAX);
    assign w_count_nxt = r_count + 16'd1;
    // A TCOUNT write on a tick edge suppresses the match; compare uses old TCMP
    assign w_match     = w_tick && !w_tcount_wr && (w_count_nxt == r_tcmp);

    // Read mux over the current register state (full 9-bit compare)
    always_comb begin
        w_rd_mux = 16'h0000;
        case (bus.mem_addr)
            IO_LED:    w_rd_mux = {6'b0, r_led};
            IO_SW:     w_rd_mux = {6'b0, r_sw_sync};
            IO_TCOUNT: w_rd_mux = r_count;
            IO_TCMP:   w_rd_mux = r_tcmp;
            IO_STATUS: w_rd_mux = {15'b0, r_flag};
            IO_HEX:    w_rd_mux = r_hex;
            default:   w_rd_mux = 16'h0000;
        endcase
    end

    // Two-flop synchronizer for the asynchronous slide switches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // CPU-writable registers: LED, timer compare and hex display
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led  <= '0;
            r_tcmp <= 16'hFFFF;
            r_hex  <= 16'h0000;
        end else if (w_wr) begin
            if (bus.mem_addr == IO_LED)  r_led  <= bus.write_data[9:0];
            if (bus.mem_addr == IO_TCMP) r_tcmp <= bus.write_data;
            if (bus.mem_addr == IO_HEX)  r_hex  <= bus.write_data;
        end
    end

    // Prescaler and tick counter; any TCOUNT write restarts both from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (w_tcount_wr) begin
            r_pre   <= '0;
            r_count <= '0;
        end else begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_tick) r_count <= w_count_nxt;
        end
    end

    // Match flag: a new match beats a simultaneous read-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else if (w_match) begin
            r_flag <= 1'b1;
        end else if (w_status_rd) begin
            r_flag <= 1'b0;
        end
    end

    // Registered read data captured on every selected read edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    // Shared return bus: only drive while this block is being read
    assign bus.read_data = w_rd ? r_rdata : 16'hzzzz;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            seg7_decode u_seg (
                .nibble (r_hex[gi*4 +: 4]),
                .seg    (w_seg[gi])
            );
        end
    endgenerate

    assign ledr = r_led;
    assign hex0 = w_seg[0];
    assign hex1 = w_seg[1];
    assign hex2 = w_seg[2];
    assign hex3 = w_seg[3];

endmodule : mmio_responder
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mmio_responder
// Brief  : Self-checking bench for mmio_responder with a behavioural model
//          of the register map and timer, directed scenarios and random bus
//          traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mmio_responder;
    import mem_bus_pkg::*;

    localparam int TB_PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3;

    mmio_responder_if bus ();

    mmio_responder #(.PRESCALE(TB_PRESCALE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .sw    (sw),
        .ledr  (ledr),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Unselected reads must leave the shared bus released
    task automatic chk_z(input string name, input logic [15:0] act);
        n_total++;
        if (act === 16'hzzzz || act === 16'h0000) n_pass++;
        else $display("FAIL %s: got %h expected released bus at %0t", name, act, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tab [16];
    bit          m_valid = 0;
    int          m_elapsed;       // cycles since last prescaler restart
    logic [9:0]  m_led, m_meta, m_sync;
    logic [15:0] m_hex, m_tcmp, m_count, m_rdata;
    logic        m_flag;

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    end

    function automatic logic [15:0] io_value(input logic [8:0] a);
        if (a == 9'h100) return {6'b0, m_led};
        if (a == 9'h140) return {6'b0, m_sync};
        if (a == 9'h180) return m_count;
        if (a == 9'h181) return m_tcmp;
        if (a == 9'h182) return {15'b0, m_flag};
        if (a == 9'h1C0) return m_hex;
        return 16'h0000;
    endfunction

    // Model advance on each clock edge, from the inputs presented to it
    always @(posedge clk) begin
        logic [1:0]  c;
        logic [8:0]  a;
        logic [15:0] d;
        logic        rd, wr, tick, set;
        c = bus.mem_cmd; a = bus.mem_addr; d = bus.write_data;
        if (reset) begin
            m_valid = 1; m_elapsed = 0;
            m_led = 0; m_meta = 0; m_sync = 0; m_hex = 0;
            m_tcmp = 16'hFFFF; m_count = 0; m_rdata = 0; m_flag = 0;
        end else if (m_valid) begin
            rd = a[8] && c == 2'b01;
            wr = a[8] && c == 2'b10;
            if (rd) m_rdata = io_value(a);
            m_sync = m_meta;
            m_meta = sw;
            m_elapsed++;
            tick = (m_elapsed % TB_PRESCALE) == 0;
            set = 0;
            if (wr && a == 9'h180) begin
                m_elapsed = 0;
                m_count   = 0;
            end else if (tick) begin
                m_count = m_count + 16'd1;
                set = (m_count == m_tcmp);
            end
            if (set) m_flag = 1;
            else if (rd && a == 9'h182) m_flag = 0;
            if (wr && a == 9'h100) m_led  = d[9:0];
            if (wr && a == 9'h181) m_tcmp = d;
            if (wr && a == 9'h1C0) m_hex  = d;
        end
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ledr", 32'(ledr), 32'(m_led));
            chk("hex0", 32'(hex0), 32'(seg_tab[m_hex[3:0]]));
            chk("hex1", 32'(hex1), 32'(seg_tab[m_hex[7:4]]));
            chk("hex2", 32'(hex2), 32'(seg_tab[m_hex[11:8]]));
            chk("hex3", 32'(hex3), 32'(seg_tab[m_hex[15:12]]));
            if (bus.mem_addr[8] && bus.mem_cmd == 2'b01)
                chk("read_data", 32'(bus.read_data), 32'(m_rdata));
            else
                chk_z("read_data_z", bus.read_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd = c; bus.mem_addr = a; bus.write_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(MNONE, 9'h000, 16'h0000);
    endtask

    task automatic read2(input logic [8:0] a, output logic [15:0] v1, output logic [15:0] v2);
        bus.mem_cmd = MREAD; bus.mem_addr = a; bus.write_data = 16'h0000;
        @(posedge clk); #1; v1 = bus.read_data;
        @(posedge clk); #1; v2 = bus.read_data;
    endtask

    initial begin
        logic [15:0] v1, v2;
        logic [8:0]  amap [8];
        logic [8:0]  a;
        logic [1:0]  c;
        logic [15:0] d;
        reset = 1; sw = 0;
        bus.mem_cmd = MNONE; bus.mem_addr = 0; bus.write_data = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        // Reset state
        chk("rst_ledr", 32'(ledr), 32'h0);
        chk("rst_hex0", 32'(hex0), 32'(7'b1000000));
        chk("rst_hex3", 32'(hex3), 32'(7'b1000000));

        // LED write and read back
        cyc(MWRITE, 9'h100, 16'h02A5);
        chk("led_wr", 32'(ledr), 32'h2A5);
        read2(9'h100, v1, v2);
        chk("led_rd", 32'(v1), 32'h02A5);

        // Switch synchronizer and unselected read
        sw = 10'h3C1;
        idle(3);
        read2(9'h140, v1, v2);
        chk("sw_rd", 32'(v1), 32'h03C1);
        bus.mem_cmd = MREAD; bus.mem_addr = 9'h040; #1;
        chk_z("unsel_z", bus.read_data);
        @(posedge clk); #1;

        // Timer reaches compare after 3 ticks; STATUS read clears
        cyc(MWRITE, 9'h181, 16'h0003);
        cyc(MWRITE, 9'h180, 16'h0000);
        idle(12);
        read2(9'h180, v1, v2);
        chk("tcount3", 32'(v1), 32'h3);
        read2(9'h182, v1, v2);
        chk("status_set", 32'(v1), 32'h1);
        read2(9'h182, v1, v2);
        chk("status_clr", 32'(v1), 32'h0);

        // STATUS read on the setting edge: old value returned, flag kept
        cyc(MWRITE, 9'h180, 16'h0000);
        cyc(MWRITE, 9'h181, 16'h0001);
        idle(2);
        read2(9'h182, v1, v2);
        chk("set_wins_old", 32'(v1), 32'h0);
        chk("set_wins_kept", 32'(v2), 32'h1);

        // TCOUNT write on a tick edge wins
        cyc(MWRITE, 9'h180, 16'h0000);
        idle(3);
        cyc(MWRITE, 9'h180, 16'h0000);
        read2(9'h180, v1, v2);
        chk("tcount_wr_tick", 32'(v1), 32'h0);

        // Hex display
        cyc(MWRITE, 9'h1C0, 16'h1F80);
        chk("hex3_1", 32'(hex3), 32'(7'b1111001));
        chk("hex2_F", 32'(hex2), 32'(7'b0001110));
        chk("hex1_8", 32'(hex1), 32'(7'b0000000));
        chk("hex0_0", 32'(hex0), 32'(7'b1000000));

        // Reset while the timer runs with the flag set
        cyc(MWRITE, 9'h181, 16'h0002);
        cyc(MWRITE, 9'h180, 16'h0000);
        idle(20);
        reset = 1;
        cyc(MWRITE, 9'h100, 16'h03FF);
        reset = 0;
        chk("rr_ledr", 32'(ledr), 32'h0);
        chk("rr_hex1", 32'(hex1), 32'(7'b1000000));
        read2(9'h181, v1, v2);
        chk("rr_tcmp", 32'(v1), 32'hFFFF);
        read2(9'h180, v1, v2);
        chk("rr_tcount", 32'(v1), 32'h0);
        read2(9'h182, v1, v2);
        chk("rr_status", 32'(v1), 32'h0);

        // Random traffic against the model
        amap[0] = 9'h100; amap[1] = 9'h140; amap[2] = 9'h180; amap[3] = 9'h181;
        amap[4] = 9'h182; amap[5] = 9'h1C0; amap[6] = 9'h1FF; amap[7] = 9'h000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) a = 9'($urandom);
            else a = amap[$urandom_range(0, 7)];
            c = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            if (a == 9'h181) d = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) sw = 10'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            cyc(c, a, d);
        end
        reset = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mmio_responder
`default_nettype wire
